// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock through a single
// full-adder cell, computed as a + ~b + ~bin with a start/done handshake.
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request honoured only in IDLE (no queuing, no restart);
    // done is a one-cycle pulse, and diff/bout/ovf stay valid until the next result load.

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] p_sh;
    logic [CW-1:0]    count;
    logic             carry;
    logic             a_msb;
    logic             b_msb;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] p_next;
    logic             last_bit;

    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign p_next    = {sum_bit, p_sh[WIDTH-1:1]};
    assign last_bit  = (count == LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == SHIFT);
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            p_sh  <= '0;
            count <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= ~b;
                        p_sh  <= '0;
                        carry <= ~bin;
                        count <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    p_sh  <= p_next;
                    carry <= carry_nxt;
                    count <= last_bit ? '0 : count + 1'b1;
                    // Final bit: the result is taken from p_next so it includes this cycle's sum.
                    if (last_bit) begin
                        diff <= p_next;
                        bout <= ~carry_nxt;
                        ovf  <= (a_msb != b_msb) && (sum_bit != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor (WIDTH=8): latency, results, held start,
// mid-operation reset, plus a queue-checked sweep against an arithmetic model.
module tb_bit_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         busy;
    logic         done;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [W+1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs[7] = '{
        '{8'd100, 8'd37, 1'b0, 8'd63,  1'b0, 1'b0},
        '{8'd5,   8'd10, 1'b0, 8'hFB,  1'b1, 1'b0},
        '{8'd0,   8'd0,  1'b1, 8'hFF,  1'b1, 1'b0},
        '{8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b1},
        '{8'h7F,  8'hFF, 1'b0, 8'h80,  1'b1, 1'b1},
        '{8'hFF,  8'hFF, 1'b1, 8'hFF,  1'b1, 1'b0},
        '{8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b0}
    };

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble the inputs after acceptance, wait (bounded) for done.
    task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bin_i,
                          output int lat, output int busy_cyc, output logic [W+1:0] res);
        @(negedge clk);
        a = a_i; b = b_i; bin = bin_i; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~a_i; b = ~b_i; bin = ~bin_i;
        lat = 1;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            busy_cyc += int'(busy);
            @(negedge clk);
            lat++;
        end
        res = {ovf, bout, diff};
    endtask

    initial begin
        int lat, busy_cyc, nd, t, seen;
        int t_done[2];
        logic bz[64];
        logic [W+1:0] res;
        logic [W+1:0] r_first, r_second;
        logic [W:0]   full;
        logic [W-1:0] ra, rb, rd;
        logic         rbin;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_diff", diff, 0);
        check("rst_flags", {bout, ovf, busy, done}, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, busy_cyc, res);
            check($sformatf("lat_%0d", i), lat, 9);
            check($sformatf("busy_%0d", i), busy_cyc, 8);
            check($sformatf("diff_%0d", i), res[W-1:0], vecs[i].d);
            check($sformatf("bout_%0d", i), res[W], vecs[i].bo);
            check($sformatf("ovf_%0d", i), res[W+1], vecs[i].ov);
            @(negedge clk);
            check($sformatf("done_pulse_%0d", i), done, 0);
            check($sformatf("hold_%0d", i), {ovf, bout, diff}, {vecs[i].ov, vecs[i].bo, vecs[i].d});
        end

        // start held high; operands changed during SHIFT must not affect the first result
        @(negedge clk);
        a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        nd = 0; t = 0; r_first = '0; r_second = '0;
        t_done[0] = 0; t_done[1] = 0;
        while (nd < 2 && t < 60) begin
            @(negedge clk);
            t++;
            bz[t] = busy;
            if (t == 1) begin a = 8'h11; b = 8'h22; end
            if (done) begin
                t_done[nd] = t;
                if (nd == 0) r_first = {ovf, bout, diff};
                else         r_second = {ovf, bout, diff};
                nd++;
            end
        end
        start = 1'b0;
        check("held_ndone", nd, 2);
        check("held_first", r_first, {1'b0, 1'b0, 8'd63});
        check("held_second", r_second, {1'b0, 1'b1, 8'hEF});
        check("held_spacing", t_done[1] - t_done[0], 10);
        check("held_idle_gap", bz[t_done[0] + 1], 1'b0);
        check("held_restart", bz[t_done[0] + 2], 1'b1);

        // reset in the 4th SHIFT cycle, with start asserted on the same edge
        @(negedge clk);
        @(negedge clk);
        a = 8'd200; b = 8'd55; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_diff", diff, 0);
        check("abort_flags", {bout, ovf}, 0);
        check("abort_state", dbg_state, 0);
        rst = 1'b0; start = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("abort_no_done", seen, 0);
        run_op(8'd200, 8'd55, 1'b0, lat, busy_cyc, res);
        check("after_abort", res, {1'b0, 1'b0, 8'd145});

        // model sweep through the expected queue
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            rd = full[W-1:0];
            exp_q.push_back({(ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]), full[W], rd});
            run_op(ra, rb, rbin, lat, busy_cyc, res);
            check($sformatf("rnd_%0d_%0h_%0h_%0b", i, ra, rb, rbin), res, exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
- Sequential subtractor: computes diff = a - b - bin on WIDTH-bit unsigned/two's-complement operands, one bit per clock, through a single full-adder cell.
- Subtraction is done as a + ~b + ~bin.
- Companion to the parallel ripple-carry adder: the small-area, reverse-operation datapath for the same ALU.
- Uses a start/done handshake with a registered result that holds until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- bin  input  1  borrow-in; captured on the accepted start.
- diff  output  WIDTH  registered result a - b - bin (mod 2^WIDTH).
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow of the two's-complement subtraction.
- busy  output  1  high while bits are being processed (SHIFT).
- done  output  1  one-cycle pulse: result valid.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high (rst sampled on the rising edge of clk).
- Reset values: state=IDLE; diff=0, bout=0, ovf=0, busy=0, done=0; internal shift registers, carry and count all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at an edge:
  - Load A<=a, B<=~b, carry<=~bin, count<=0.
  - Latch sign bits a[WIDTH-1] and b[WIDTH-1].
  - Go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle:
  - s = A[0]^B[0]^carry.
  - carry <= majority(A[0], B[0], carry).
  - A and B shift right by 1.
  - Internal partial register P shifts right with s entering at the MSB.
  - count increments.
  - After exactly WIDTH SHIFT cycles (count == WIDTH-1 on the last one), go to DONE.
- Entry into DONE (same edge as the final bit):
  - diff <= final P, including the last bit.
  - bout <= ~final_carry.
  - ovf <= (a_msb != b_msb) && (diff_msb != a_msb).
- DONE: done=1 for exactly one cycle, then IDLE. diff, bout and ovf hold until the next result load or reset.
- busy = 1 iff state==SHIFT. done = 1 iff state==DONE. Both are registered, so there are no combinational paths from inputs.
- Latency: start sampled at edge N -> busy high for cycles N+1..N+WIDTH -> done high in cycle N+WIDTH+1.
- Next start is accepted at the earliest one cycle after done, i.e. back-to-back operation every WIDTH+2 cycles.
- start while in SHIFT or DONE is ignored: no restart, no queuing. a, b and bin may change freely after acceptance without affecting the result.
- rst mid-operation: aborts at that edge. All state and outputs return to reset values and done is not produced. A start sampled on the same edge as rst is ignored.
- Width rules:
  - count is clog2(WIDTH) bits and wraps only through the FSM, never past WIDTH-1.
  - Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- Reset, then a=100, b=37, bin=0, start 1 cycle -> busy high 8 cycles; done pulse at cycle 9 after start; diff=63, bout=0, ovf=0.
- a=5, b=10, bin=0 -> diff=251 (0xFB), bout=1, ovf=0. a=0, b=0, bin=1 -> diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Start held high continuously, with a and b changed during SHIFT:
  - first result matches the captured operands;
  - the next op is accepted only in the IDLE cycle after done;
  - done pulses are spaced exactly 10 cycles apart.
- Assert rst at the 4th SHIFT cycle -> next cycle busy=0, diff=0, bout=0, ovf=0, and no done pulse. A fresh op afterwards (200-55) gives diff=145.
- Random sweep of 1000 (a, b, bin) triples against the golden model {bout,diff} = a - b - bin (WIDTH+1 bits), with signed overflow compared. Repeat with WIDTH=4 and WIDTH=16.
